// File: rtl/mem_stage_pkg.sv
// Shared widths and controller state encodings for the MEM stage.
package mem_stage_pkg;
    localparam int WORD_LEN          = 32;
    localparam int REG_FILE_ADDR_LEN = 5;
    localparam int SRAM_ADDR_LEN     = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/sram_controller.sv
// SRAM access controller: IDLE/BUSY/DONE FSM, SRAM-side registers,
// pipeline freeze and the captured read word.
module sram_controller
    import mem_stage_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mem_r_en,
    input  logic                     mem_w_en,
    input  logic [SRAM_ADDR_LEN-1:0] word_addr,
    input  logic [WORD_LEN-1:0]      st_value,
    output logic                     sram_req,
    output logic                     sram_we,
    output logic [SRAM_ADDR_LEN-1:0] sram_addr,
    output logic [WORD_LEN-1:0]      sram_wdata,
    input  logic [WORD_LEN-1:0]      sram_rdata,
    input  logic                     sram_ready,
    output logic                     freeze,
    output logic [WORD_LEN-1:0]      read_value
);
    state_t state_q, state_d;
    logic   access;

    assign access = mem_r_en | mem_w_en;

    // Freeze upstream until the access has completed (DONE releases it).
    assign freeze = access & (state_q != DONE);

    // Request is decoded from state so reset drops it asynchronously.
    assign sram_req = (state_q == BUSY);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic; BUSY waits for ready with no timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (access) state_d = BUSY;
            BUSY:    if (sram_ready) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // SRAM-side registers latch in IDLE and hold through BUSY; a combined
    // read+write request is treated as a store.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sram_addr  <= '0;
            sram_wdata <= '0;
            sram_we    <= 1'b0;
        end else if (state_q == IDLE && access) begin
            sram_addr  <= word_addr;
            sram_wdata <= st_value;
            sram_we    <= mem_w_en;
        end
    end

    // Read register captures the SRAM word on the completing BUSY cycle only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                             read_value <= '0;
        else if (state_q == BUSY && sram_ready) read_value <= sram_rdata;
    end
endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: SRAM controller plus the MEM/WB pipeline register.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         WB_EN_in,
    input  logic                         MEM_R_EN_in,
    input  logic                         MEM_W_EN_in,
    input  logic [WORD_LEN-1:0]          ALU_res_in,
    input  logic [WORD_LEN-1:0]          ST_value_in,
    input  logic [REG_FILE_ADDR_LEN-1:0] dest_in,
    output logic                         sram_req,
    output logic                         sram_we,
    output logic [SRAM_ADDR_LEN-1:0]     sram_addr,
    output logic [WORD_LEN-1:0]          sram_wdata,
    input  logic [WORD_LEN-1:0]          sram_rdata,
    input  logic                         sram_ready,
    output logic                         freeze,
    output logic                         WB_EN_out,
    output logic                         MEM_R_EN_out,
    output logic [WORD_LEN-1:0]          ALU_res_out,
    output logic [WORD_LEN-1:0]          mem_read_value,
    output logic [REG_FILE_ADDR_LEN-1:0] dest_out
);
    logic [WORD_LEN-1:0] read_value;

    // Byte address -> word address; low two and high bits are dropped.
    sram_controller u_ctrl (
        .clk        (clk),
        .rst        (rst),
        .mem_r_en   (MEM_R_EN_in),
        .mem_w_en   (MEM_W_EN_in),
        .word_addr  (ALU_res_in[17:2]),
        .st_value   (ST_value_in),
        .sram_req   (sram_req),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .sram_ready (sram_ready),
        .freeze     (freeze),
        .read_value (read_value)
    );

    // MEM/WB register: bubble the control bits while frozen, hold data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            WB_EN_out      <= 1'b0;
            MEM_R_EN_out   <= 1'b0;
            ALU_res_out    <= '0;
            mem_read_value <= '0;
            dest_out       <= '0;
        end else if (freeze) begin
            WB_EN_out      <= 1'b0;
            MEM_R_EN_out   <= 1'b0;
        end else begin
            WB_EN_out      <= WB_EN_in;
            MEM_R_EN_out   <= MEM_R_EN_in;
            ALU_res_out    <= ALU_res_in;
            mem_read_value <= read_value;
            dest_out       <= dest_in;
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU op, load, slow store, reset mid-access,
// combined R/W with ignored address bits, back-to-back loads.
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        WB_EN_in, MEM_R_EN_in, MEM_W_EN_in;
    logic [31:0] ALU_res_in, ST_value_in, sram_wdata, sram_rdata;
    logic [4:0]  dest_in, dest_out;
    logic        sram_req, sram_we, sram_ready, freeze;
    logic [15:0] sram_addr;
    logic        WB_EN_out, MEM_R_EN_out;
    logic [31:0] ALU_res_out, mem_read_value;

    int ncmp = 0;
    int nfail = 0;
    int frz_cnt;

    mem_stage dut (
        .clk(clk), .rst(rst),
        .WB_EN_in(WB_EN_in), .MEM_R_EN_in(MEM_R_EN_in), .MEM_W_EN_in(MEM_W_EN_in),
        .ALU_res_in(ALU_res_in), .ST_value_in(ST_value_in), .dest_in(dest_in),
        .sram_req(sram_req), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_ready(sram_ready),
        .freeze(freeze), .WB_EN_out(WB_EN_out), .MEM_R_EN_out(MEM_R_EN_out),
        .ALU_res_out(ALU_res_out), .mem_read_value(mem_read_value), .dest_out(dest_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic wb, input logic r, input logic w,
                          input logic [31:0] alu, input logic [31:0] st, input logic [4:0] d);
        WB_EN_in = wb; MEM_R_EN_in = r; MEM_W_EN_in = w;
        ALU_res_in = alu; ST_value_in = st; dest_in = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; sram_ready = 1'b0; sram_rdata = '0;
        set_in(0, 0, 0, 32'h0, 32'h0, 5'd0);
        #12;
        // Reset state
        chk("rst_req",   {31'b0, sram_req}, 0);
        chk("rst_we",    {31'b0, sram_we}, 0);
        chk("rst_addr",  {16'b0, sram_addr}, 0);
        chk("rst_wdata", sram_wdata, 0);
        chk("rst_freeze", {31'b0, freeze}, 0);
        chk("rst_wb",    {31'b0, WB_EN_out}, 0);
        chk("rst_alu",   ALU_res_out, 0);
        chk("rst_mrv",   mem_read_value, 0);
        chk("rst_dest",  {27'b0, dest_out}, 0);
        rst = 1'b1;

        // ALU op: single cycle, no freeze, no request
        set_in(1, 0, 0, 32'h42, 32'h0, 5'd5);
        #1;
        chk("alu_freeze", {31'b0, freeze}, 0);
        chk("alu_req",    {31'b0, sram_req}, 0);
        tick();
        chk("alu_res",  ALU_res_out, 32'h42);
        chk("alu_dest", {27'b0, dest_out}, 5);
        chk("alu_wb",   {31'b0, WB_EN_out}, 1);
        chk("alu_req2", {31'b0, sram_req}, 0);

        // Load from 0x408, ready in first BUSY cycle
        set_in(1, 1, 0, 32'h408, 32'h0, 5'd3);
        #1;
        chk("ld_freeze_idle", {31'b0, freeze}, 1);
        chk("ld_req_idle",    {31'b0, sram_req}, 0);
        tick();
        chk("ld_req_busy",    {31'b0, sram_req}, 1);
        chk("ld_addr",        {16'b0, sram_addr}, 32'h0102);
        chk("ld_we",          {31'b0, sram_we}, 0);
        chk("ld_freeze_busy", {31'b0, freeze}, 1);
        chk("ld_bubble",      {31'b0, WB_EN_out}, 0);
        chk("ld_alu_hold",    ALU_res_out, 32'h42);
        sram_ready = 1'b1; sram_rdata = 32'hDEADBEEF;
        tick();
        sram_ready = 1'b0; sram_rdata = 32'h0;
        #1;
        chk("ld_freeze_done", {31'b0, freeze}, 0);
        chk("ld_req_done",    {31'b0, sram_req}, 0);
        tick();
        chk("ld_mrv",  mem_read_value, 32'hDEADBEEF);
        chk("ld_mren", {31'b0, MEM_R_EN_out}, 1);
        chk("ld_wb",   {31'b0, WB_EN_out}, 1);
        chk("ld_dest", {27'b0, dest_out}, 3);

        // Store 0x12345678 to 0x10, ready after 4 BUSY cycles
        set_in(0, 0, 1, 32'h10, 32'h12345678, 5'd0);
        sram_rdata = 32'hDEADBEEF;
        #1;
        frz_cnt = freeze ? 1 : 0;
        tick();
        for (int k = 1; k <= 4; k++) begin
            chk("st_req",   {31'b0, sram_req}, 1);
            chk("st_we",    {31'b0, sram_we}, 1);
            chk("st_addr",  {16'b0, sram_addr}, 32'h0004);
            chk("st_wdata", sram_wdata, 32'h12345678);
            chk("st_wb",    {31'b0, WB_EN_out}, 0);
            if (freeze) frz_cnt++;
            if (k == 4) sram_ready = 1'b1;
            tick();
        end
        sram_ready = 1'b0;
        if (freeze) frz_cnt++;
        chk("st_freeze_cycles", frz_cnt, 5);
        chk("st_req_done", {31'b0, sram_req}, 0);
        tick();
        chk("st_wb_out", {31'b0, WB_EN_out}, 0);
        chk("st_mren",   {31'b0, MEM_R_EN_out}, 0);
        chk("st_stale",  mem_read_value, 32'hDEADBEEF);

        // Reset in the 2nd BUSY cycle of a load
        set_in(1, 1, 0, 32'h20, 32'h0, 5'd7);
        sram_rdata = 32'h00000BAD;
        tick();
        tick();
        chk("rb_req_busy2", {31'b0, sram_req}, 1);
        #2 rst = 1'b0;
        #1;
        chk("rb_req_drop", {31'b0, sram_req}, 0);
        chk("rb_we",       {31'b0, sram_we}, 0);
        chk("rb_addr",     {16'b0, sram_addr}, 0);
        chk("rb_alu",      ALU_res_out, 0);
        chk("rb_mrv",      mem_read_value, 0);
        sram_ready = 1'b1;
        tick();
        set_in(0, 0, 0, 32'h0, 32'h0, 5'd0);
        rst = 1'b1;
        #1;
        chk("rb_freeze_idle", {31'b0, freeze}, 0);
        tick();
        sram_ready = 1'b0;
        chk("rb_req_after", {31'b0, sram_req}, 0);
        chk("rb_mrv_after", mem_read_value, 0);
        chk("rb_wb_after",  {31'b0, WB_EN_out}, 0);

        // R and W both set: store; address bits outside [17:2] ignored
        set_in(0, 1, 1, 32'hFFFC0007, 32'hA5A5A5A5, 5'd9);
        tick();
        chk("rw_we",   {31'b0, sram_we}, 1);
        chk("rw_addr", {16'b0, sram_addr}, 32'h0001);
        sram_ready = 1'b1;
        tick();
        sram_ready = 1'b0;
        tick();
        chk("rw_mren", {31'b0, MEM_R_EN_out}, 1);
        chk("rw_wb",   {31'b0, WB_EN_out}, 0);

        // Back-to-back loads to 0x0 and 0x4
        set_in(1, 1, 0, 32'h0, 32'h0, 5'd1);
        tick();
        chk("bb1_bubble1", {31'b0, WB_EN_out}, 0);
        chk("bb1_addr",    {16'b0, sram_addr}, 0);
        sram_ready = 1'b1; sram_rdata = 32'h11;
        tick();
        sram_ready = 1'b0;
        chk("bb1_bubble2", {31'b0, WB_EN_out}, 0);
        tick();
        chk("bb1_mrv",  mem_read_value, 32'h11);
        chk("bb1_wb",   {31'b0, WB_EN_out}, 1);
        chk("bb1_dest", {27'b0, dest_out}, 1);
        set_in(1, 1, 0, 32'h4, 32'h0, 5'd2);
        tick();
        chk("bb2_bubble1", {31'b0, WB_EN_out}, 0);
        chk("bb2_addr",    {16'b0, sram_addr}, 1);
        sram_ready = 1'b1; sram_rdata = 32'h22;
        tick();
        sram_ready = 1'b0;
        chk("bb2_bubble2", {31'b0, WB_EN_out}, 0);
        tick();
        chk("bb2_mrv",  mem_read_value, 32'h22);
        chk("bb2_wb",   {31'b0, WB_EN_out}, 1);
        chk("bb2_dest", {27'b0, dest_out}, 2);
        set_in(0, 0, 0, 32'h0, 32'h0, 5'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
